// File: rtl/pipelined_prefix_addsub.sv
// Pipelined Kogge-Stone adder/subtractor with valid/ready handshake and tag sideband.
// Define PREFIX_ADDER_FLAGS_EN to add the registered zero/negative/overflow flag outputs.
module pipelined_prefix_addsub #(
  parameter int WIDTH       = 16,
  parameter int STAGE_SPLIT = 2,
  parameter int TAG_W       = 4
) (
  input  logic             clk,
  input  logic             rst,
  input  logic             in_valid,
  output logic             in_ready,
  input  logic [WIDTH-1:0] in_a,
  input  logic [WIDTH-1:0] in_b,
  input  logic             in_cin,
  input  logic             in_sub,
  input  logic [TAG_W-1:0] in_tag,
  output logic             out_valid,
  input  logic             out_ready,
  output logic [WIDTH-1:0] out_s,
  output logic             out_cout,
  output logic [TAG_W-1:0] out_tag
`ifdef PREFIX_ADDER_FLAGS_EN
  ,
  output logic             out_z,
  output logic             out_n,
  output logic             out_v
`endif
);

  localparam int LEVELS = $clog2(WIDTH);

  // Handshake: a transfer happens on valid & ready at either end. The only stall
  // source is a result the consumer refuses; it freezes every stage, bubbles included.
  logic stall;
  logic en;
  assign stall    = out_valid & ~out_ready;
  assign en       = ~stall;
  assign in_ready = en;

  logic [WIDTH-1:0] a_q;
  logic [WIDTH-1:0] b_q;
  logic             c0_q;
  logic             v0_q;
  logic [TAG_W-1:0] tag0_q;

  always_ff @(posedge clk) begin
    if (rst) begin
      a_q    <= '0;
      b_q    <= '0;
      c0_q   <= 1'b0;
      v0_q   <= 1'b0;
      tag0_q <= '0;
    end else if (en) begin
      a_q    <= in_a;
      b_q    <= in_sub ? ~in_b : in_b;
      c0_q   <= in_sub | in_cin;
      v0_q   <= in_valid;
      tag0_q <= in_tag;
    end
  end

  // Per-level inputs: running generate/propagate plus the bit propagates,
  // carry-in, valid and tag that ride along for the final sum.
  logic [WIDTH-1:0] g_b   [LEVELS];
  logic [WIDTH-1:0] p_b   [LEVELS];
  logic [WIDTH-1:0] p0_b  [LEVELS];
  logic             c0_b  [LEVELS];
  logic             v_b   [LEVELS];
  logic [TAG_W-1:0] tag_b [LEVELS];

  logic [WIDTH-1:0] p_init;
  logic [WIDTH-1:0] g_init;
  assign p_init   = a_q ^ b_q;
  assign g_init   = a_q & b_q;
  assign g_b[0]   = {g_init[WIDTH-1:1], g_init[0] | (p_init[0] & c0_q)};
  assign p_b[0]   = p_init;
  assign p0_b[0]  = p_init;
  assign c0_b[0]  = c0_q;
  assign v_b[0]   = v0_q;
  assign tag_b[0] = tag0_q;

  for (genvar lv = 0; lv < LEVELS; lv++) begin : g_level
    localparam int D = 1 << lv;
    // Shifting by D leaves zeros in the low D bits, so cells whose partner
    // would lie below bit 0 degrade to pass-through.
    logic [WIDTH-1:0] g_n;
    assign g_n = g_b[lv] | (p_b[lv] & (g_b[lv] << D));

    if (lv == LEVELS - 1) begin : g_final
      logic [WIDTH-1:0] s_n;
      assign s_n = p0_b[lv] ^ {g_n[WIDTH-2:0], c0_b[lv]};

      always_ff @(posedge clk) begin
        if (rst) begin
          out_valid <= 1'b0;
          out_s     <= '0;
          out_cout  <= 1'b0;
          out_tag   <= '0;
`ifdef PREFIX_ADDER_FLAGS_EN
          out_z     <= 1'b0;
          out_n     <= 1'b0;
          out_v     <= 1'b0;
`endif
        end else if (en) begin
          out_valid <= v_b[lv];
          out_s     <= s_n;
          out_cout  <= g_n[WIDTH-1];
          out_tag   <= tag_b[lv];
`ifdef PREFIX_ADDER_FLAGS_EN
          out_z     <= (s_n == '0);
          out_n     <= s_n[WIDTH-1];
          out_v     <= g_n[WIDTH-2] ^ g_n[WIDTH-1];
`endif
        end
      end
    end else begin : g_mid
      localparam logic [WIDTH-1:0] LOW = {WIDTH{1'b1}} >> (WIDTH - D);
      logic [WIDTH-1:0] p_n;
      assign p_n = p_b[lv] & ((p_b[lv] << D) | LOW);

      if (((lv + 1) % STAGE_SPLIT) == 0) begin : g_reg
        logic [WIDTH-1:0] g_q;
        logic [WIDTH-1:0] p_q;
        logic [WIDTH-1:0] p0_q;
        logic             c0_r;
        logic             v_q;
        logic [TAG_W-1:0] tag_q;

        always_ff @(posedge clk) begin
          if (rst) begin
            g_q   <= '0;
            p_q   <= '0;
            p0_q  <= '0;
            c0_r  <= 1'b0;
            v_q   <= 1'b0;
            tag_q <= '0;
          end else if (en) begin
            g_q   <= g_n;
            p_q   <= p_n;
            p0_q  <= p0_b[lv];
            c0_r  <= c0_b[lv];
            v_q   <= v_b[lv];
            tag_q <= tag_b[lv];
          end
        end

        assign g_b[lv+1]   = g_q;
        assign p_b[lv+1]   = p_q;
        assign p0_b[lv+1]  = p0_q;
        assign c0_b[lv+1]  = c0_r;
        assign v_b[lv+1]   = v_q;
        assign tag_b[lv+1] = tag_q;
      end else begin : g_pass
        assign g_b[lv+1]   = g_n;
        assign p_b[lv+1]   = p_n;
        assign p0_b[lv+1]  = p0_b[lv];
        assign c0_b[lv+1]  = c0_b[lv];
        assign v_b[lv+1]   = v_b[lv];
        assign tag_b[lv+1] = tag_b[lv];
      end
    end
  end

endmodule

// File: tb/tb_pipelined_prefix_addsub.sv
// Bench for pipelined_prefix_addsub: arithmetic reference model, scoreboard queue,
// directed corner cases, throughput, backpressure, mid-flight reset and random traffic.
module tb_pipelined_prefix_addsub;

  localparam int W   = 16;
  localparam int TW  = 4;
  localparam int LAT = 3;
`ifdef PREFIX_ADDER_FLAGS_EN
  localparam int EW = W + 1 + TW + 3;
`else
  localparam int EW = W + 1 + TW;
`endif

  logic          clk = 1'b0;
  logic          rst = 1'b1;
  logic          in_valid = 1'b0;
  logic          in_ready;
  logic [W-1:0]  in_a = '0;
  logic [W-1:0]  in_b = '0;
  logic          in_cin = 1'b0;
  logic          in_sub = 1'b0;
  logic [TW-1:0] in_tag = '0;
  logic          out_valid;
  logic          out_ready = 1'b1;
  logic [W-1:0]  out_s;
  logic          out_cout;
  logic [TW-1:0] out_tag;
`ifdef PREFIX_ADDER_FLAGS_EN
  logic          out_z;
  logic          out_n;
  logic          out_v;
`endif

  always #5 clk = ~clk;

  pipelined_prefix_addsub #(.WIDTH(W), .STAGE_SPLIT(2), .TAG_W(TW)) dut (
    .clk       (clk),
    .rst       (rst),
    .in_valid  (in_valid),
    .in_ready  (in_ready),
    .in_a      (in_a),
    .in_b      (in_b),
    .in_cin    (in_cin),
    .in_sub    (in_sub),
    .in_tag    (in_tag),
    .out_valid (out_valid),
    .out_ready (out_ready),
    .out_s     (out_s),
    .out_cout  (out_cout),
`ifdef PREFIX_ADDER_FLAGS_EN
    .out_tag   (out_tag),
    .out_z     (out_z),
    .out_n     (out_n),
    .out_v     (out_v)
`else
    .out_tag   (out_tag)
`endif
  );

  logic [EW-1:0] act_out;
`ifdef PREFIX_ADDER_FLAGS_EN
  assign act_out = {out_cout, out_s, out_tag, out_z, out_n, out_v};
`else
  assign act_out = {out_cout, out_s, out_tag};
`endif

  logic [EW-1:0] exp_q[$];
  logic [EW-1:0] exp_e;
  logic [EW-1:0] prev_out;
  logic          prev_hold = 1'b0;
  int checks = 0;
  int failures = 0;
  int cycle = 0;
  int n_out = 0;
  int first_acc = -1;
  int first_out = -1;
  int last_out = -1;

  task automatic check(input string name, input logic [63:0] act, input logic [63:0] req);
    checks++;
    if (act !== req) begin
      failures++;
      $display("FAIL %s actual=0x%0h required=0x%0h", name, act, req);
    end
  endtask

  // Reference: plain integer addition of a, the (possibly inverted) b and carry-in.
  function automatic logic [W:0] model(input logic [W-1:0] a, input logic [W-1:0] b,
                                       input logic cin, input logic sub);
    logic [W-1:0] bp;
    logic         c;
    bp = sub ? ~b : b;
    c  = sub ? 1'b1 : cin;
    return {1'b0, a} + {1'b0, bp} + {{W{1'b0}}, c};
  endfunction

  // {z, n, v}; overflow by the sign rule: same-signed operands, differently signed result.
  function automatic logic [2:0] flags_of(input logic [W-1:0] a, input logic [W-1:0] b,
                                          input logic cin, input logic sub);
    logic [W:0]   r;
    logic [W-1:0] bp;
    r  = model(a, b, cin, sub);
    bp = sub ? ~b : b;
    return {r[W-1:0] == '0, r[W-1], (a[W-1] == bp[W-1]) && (r[W-1] != a[W-1])};
  endfunction

  function automatic logic [EW-1:0] pack(input logic [W-1:0] a, input logic [W-1:0] b,
                                         input logic cin, input logic sub,
                                         input logic [TW-1:0] tag);
`ifdef PREFIX_ADDER_FLAGS_EN
    return {model(a, b, cin, sub), tag, flags_of(a, b, cin, sub)};
`else
    return {model(a, b, cin, sub), tag};
`endif
  endfunction

  // Compare process: handshake rule, stall stability and in-order scoreboard.
  always @(negedge clk) begin
    cycle++;
    if (rst) begin
      exp_q.delete();
      prev_hold = 1'b0;
    end else begin
      check("in_ready_rule", in_ready, !(out_valid && !out_ready));
      if (prev_hold) begin
        check("hold_valid", out_valid, 1);
        check("hold_data", act_out, prev_out);
      end
      if (out_valid && out_ready) begin
        if (exp_q.size() == 0) begin
          checks++;
          failures++;
          $display("FAIL unexpected_result actual=0x%0h required=none", act_out);
        end else begin
          exp_e = exp_q.pop_front();
          check("result", act_out, exp_e);
        end
        n_out++;
        if (first_out < 0) first_out = cycle;
        last_out = cycle;
      end
      if (in_valid && in_ready) begin
        exp_q.push_back(pack(in_a, in_b, in_cin, in_sub, in_tag));
        if (first_acc < 0) first_acc = cycle;
      end
      prev_hold = out_valid && !out_ready;
      prev_out  = act_out;
    end
  end

  task automatic send(input logic [W-1:0] a, input logic [W-1:0] b, input logic cin,
                      input logic sub, input logic [TW-1:0] tag);
    bit acc = 1'b0;
    in_valid = 1'b1;
    in_a = a;
    in_b = b;
    in_cin = cin;
    in_sub = sub;
    in_tag = tag;
    for (int k = 0; k < 200 && !acc; k++) begin
      @(negedge clk);
      acc = in_ready;
      @(posedge clk);
      #1;
    end
    if (!acc) begin
      checks++;
      failures++;
      $display("FAIL send_timeout actual=not_accepted required=accepted");
    end
    in_valid = 1'b0;
  endtask

  task automatic send_rand();
    send(W'($urandom), W'($urandom), 1'($urandom), 1'($urandom), TW'($urandom));
  endtask

  task automatic directed(input string name, input logic [W-1:0] a, input logic [W-1:0] b,
                          input logic cin, input logic sub, input logic [TW-1:0] tag,
                          input logic [W-1:0] es, input logic ec, input logic [2:0] ef);
    int n = 0;
    bit seen = 1'b0;
    check({name, "_model"}, model(a, b, cin, sub), {ec, es});
    check({name, "_flags_model"}, flags_of(a, b, cin, sub), ef);
    send(a, b, cin, sub, tag);
    for (int k = 1; k <= 10 && !seen; k++) begin
      @(negedge clk);
      if (out_valid) begin
        seen = 1'b1;
        n = k;
      end
    end
    check({name, "_latency"}, n, LAT);
    check({name, "_s"}, out_s, es);
    check({name, "_cout"}, out_cout, ec);
    check({name, "_tag"}, out_tag, tag);
`ifdef PREFIX_ADDER_FLAGS_EN
    check({name, "_flags"}, {out_z, out_n, out_v}, ef);
`endif
    @(posedge clk);
    #1;
  endtask

  task automatic drain(input string name);
    for (int k = 0; k < 60 && exp_q.size() != 0; k++) @(negedge clk);
    repeat (4) @(negedge clk);
    check({name, "_drained"}, exp_q.size(), 0);
    @(posedge clk);
    #1;
  endtask

  initial begin
    #500000;
    $display("FAIL watchdog actual=timeout required=finish");
    $fatal(1, "watchdog");
  end

  initial begin
    bit got;
    bit saw_ready_low;
    bit done;

    // Reset state.
    repeat (3) @(posedge clk);
    @(negedge clk);
    check("rst_out_valid", out_valid, 0);
    check("rst_out_s", out_s, 0);
    check("rst_out_cout", out_cout, 0);
    check("rst_out_tag", out_tag, 0);
    @(posedge clk);
    #1;
    rst = 1'b0;
    @(negedge clk);
    check("post_rst_in_ready", in_ready, 1);
    @(posedge clk);
    #1;

    // Directed corner cases; literal expectations also pin the model.
    directed("add_wrap", 16'hFFFF, 16'h0001, 1'b0, 1'b0, 4'h3, 16'h0000, 1'b1, 3'b100);
    directed("sub_borrow", 16'h0005, 16'h0007, 1'b1, 1'b1, 4'h5, 16'hFFFE, 1'b0, 3'b010);
    directed("ovf", 16'h7FFF, 16'h0001, 1'b0, 1'b0, 4'h9, 16'h8000, 1'b0, 3'b011);
    directed("ovf_cin", 16'h7FFE, 16'h0001, 1'b1, 1'b0, 4'hA, 16'h8000, 1'b0, 3'b011);
    directed("sub_equal", 16'h1234, 16'h1234, 1'b0, 1'b1, 4'hC, 16'h0000, 1'b1, 3'b100);
    drain("directed");

    // Throughput: 8 back-to-back ops.
    out_ready = 1'b1;
    n_out = 0;
    first_acc = -1;
    first_out = -1;
    for (int i = 0; i < 8; i++) send_rand();
    drain("throughput");
    check("tp_count", n_out, 8);
    check("tp_first_latency", first_out - first_acc, LAT);
    check("tp_consecutive", last_out - first_out, 7);

    // Backpressure: 5 ops, consumer stalls for 6 cycles once the first result shows.
    n_out = 0;
    saw_ready_low = 1'b0;
    got = 1'b0;
    out_ready = 1'b0;
    fork
      begin
        for (int i = 0; i < 5; i++) send_rand();
      end
      begin
        for (int k = 0; k < 20 && !got; k++) begin
          @(negedge clk);
          got = out_valid;
        end
        repeat (6) begin
          @(negedge clk);
          if (!in_ready) saw_ready_low = 1'b1;
        end
        @(posedge clk);
        #1;
        out_ready = 1'b1;
      end
    join
    drain("backpressure");
    check("bp_valid_seen", got, 1);
    check("bp_in_ready_dropped", saw_ready_low, 1);
    check("bp_count", n_out, 5);

    // Reset one cycle before the first of two results would appear.
    send(16'h0102, 16'h0304, 1'b0, 1'b0, 4'h1);
    send(16'h0506, 16'h0708, 1'b1, 1'b0, 4'h2);
    rst = 1'b1;
    @(posedge clk);
    #1;
    rst = 1'b0;
    @(negedge clk);
    check("midrst_out_valid", out_valid, 0);
    check("midrst_out_s", out_s, 0);
    repeat (5) begin
      @(negedge clk);
      check("midrst_no_stale", out_valid, 0);
    end
    @(posedge clk);
    #1;
    directed("after_rst", 16'h00F0, 16'h0F0F, 1'b1, 1'b0, 4'h6, 16'h1000, 1'b0, 3'b000);
    drain("after_rst");

    // Random traffic with random gaps and random consumer stalls.
    done = 1'b0;
    fork
      begin
        for (int i = 0; i < 300; i++) begin
          send_rand();
          repeat ($urandom_range(0, 2)) begin
            @(posedge clk);
            #1;
          end
        end
        done = 1'b1;
      end
      begin
        while (!done) begin
          @(posedge clk);
          #1;
          out_ready = ($urandom_range(0, 3) != 0);
        end
      end
    join
    out_ready = 1'b1;
    drain("random");

    $display("TB_RESULT checks=%0d failures=%0d", checks, failures);
    $finish;
  end

endmodule
